// File: rtl/scoreboard_stall_unit.sv
// Register-hazard scoreboard for decode: per-register pending-write counters, combinational stall.
// Optional SCOREBOARD_PERF_EN adds a saturating stall_cycles counter output.
module scoreboard_stall_unit #(
  parameter int NREG  = 8,
  parameter int AW    = 3,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_src1,
  input  logic            issue_src1_en,
  input  logic [AW-1:0]   issue_src2,
  input  logic            issue_src2_en,
  input  logic [AW-1:0]   issue_dst,
  input  logic            issue_dst_en,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic            flush,
  output logic            stall,
  output logic            issue_fire,
  output logic [NREG-1:0] pending_mask,
  output logic            busy,
`ifdef SCOREBOARD_PERF_EN
  output logic [15:0]     stall_cycles,
`endif
  output logic            err_underflow
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                       err_underflow_q, err_underflow_d;
  logic [NREG-1:0]            inc_v, dec_v;
  logic [CNT_W-1:0]           c_src1, c_src2, c_dst, c_wb;
  logic                       rel1, rel2, haz1, haz2, sat;

  assign c_src1 = cnt_q[issue_src1];
  assign c_src2 = cnt_q[issue_src2];
  assign c_dst  = cnt_q[issue_dst];
  assign c_wb   = cnt_q[wb_addr];

  // A write-back retiring the last pending write is forwarded to this cycle's read.
  assign rel1 = wb_valid && (wb_addr == issue_src1) && (c_src1 == CNT_ONE);
  assign rel2 = wb_valid && (wb_addr == issue_src2) && (c_src2 == CNT_ONE);
  assign haz1 = issue_src1_en && (c_src1 != CNT_ZERO) && !rel1;
  assign haz2 = issue_src2_en && (c_src2 != CNT_ZERO) && !rel2;
  assign sat  = issue_dst_en && (c_dst == CNT_MAX) && !(wb_valid && (wb_addr == issue_dst));

  assign stall      = issue_valid && (haz1 || haz2 || sat);
  assign issue_fire = issue_valid && !stall;

  always_comb begin
    inc_v = '0;
    dec_v = '0;
    for (int r = 0; r < NREG; r++) begin
      inc_v[r] = issue_fire && issue_dst_en && (issue_dst == AW'(r));
      dec_v[r] = wb_valid && (wb_addr == AW'(r)) && (cnt_q[r] != CNT_ZERO);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_v[r] && !dec_v[r])      cnt_d[r] = cnt_q[r] + CNT_ONE;
        else if (dec_v[r] && !inc_v[r]) cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
    err_underflow_d = err_underflow_q || (wb_valid && (c_wb == CNT_ZERO));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q           <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int r = 0; r < NREG; r++) pending_mask[r] = (cnt_q[r] != CNT_ZERO);
  end

  assign busy          = |pending_mask;
  assign err_underflow = err_underflow_q;

`ifdef SCOREBOARD_PERF_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cycles_q <= '0;
    else       stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_scoreboard_stall_unit.sv
// Directed + random bench for scoreboard_stall_unit against an integer-array reference model.
module tb_scoreboard_stall_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_src1_en, issue_src2_en, issue_dst_en, wb_valid, flush;
  logic [2:0] issue_src1, issue_src2, issue_dst, wb_addr;
  logic       stall, issue_fire, busy, err_underflow;
  logic [7:0] pending_mask;
`ifdef SCOREBOARD_PERF_EN
  logic [15:0] stall_cycles;
  int          m_stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;
  int m_cnt[8];
  bit m_err;

  scoreboard_stall_unit dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid),
    .issue_src1(issue_src1), .issue_src1_en(issue_src1_en),
    .issue_src2(issue_src2), .issue_src2_en(issue_src2_en),
    .issue_dst(issue_dst), .issue_dst_en(issue_dst_en),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .stall(stall), .issue_fire(issue_fire),
    .pending_mask(pending_mask), .busy(busy),
`ifdef SCOREBOARD_PERF_EN
    .stall_cycles(stall_cycles),
`endif
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_mask();
    logic [7:0] m = '0;
    for (int i = 0; i < 8; i++) m[i] = (m_cnt[i] > 0);
    return m;
  endfunction

  function automatic bit m_stall(input bit v, input int s1, input bit s1e, input int s2, input bit s2e,
                                 input int d, input bit de, input bit wv, input int wa);
    bit h1, h2, st;
    h1 = s1e && m_cnt[s1] > 0 && !(wv && wa == s1 && m_cnt[s1] == 1);
    h2 = s2e && m_cnt[s2] > 0 && !(wv && wa == s2 && m_cnt[s2] == 1);
    st = de && m_cnt[d] == 3 && !(wv && wa == d);
    return v && (h1 || h2 || st);
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".pending_mask"}, pending_mask, m_mask());
    chk({tag, ".busy"}, busy, (m_mask() != 0));
    chk({tag, ".err_underflow"}, err_underflow, m_err);
`ifdef SCOREBOARD_PERF_EN
    chk({tag, ".stall_cycles"}, stall_cycles, m_stall_cycles);
`endif
  endtask

  // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
  task automatic do_reset();
    issue_valid = 0; issue_src1_en = 0; issue_src2_en = 0; issue_dst_en = 0;
    wb_valid = 0; flush = 0; issue_src1 = 0; issue_src2 = 0; issue_dst = 0; wb_addr = 0;
    #2 reset = 1'b1;
    #1;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err = 0;
`ifdef SCOREBOARD_PERF_EN
    m_stall_cycles = 0;
`endif
    check_state("reset");
    chk("reset.stall", stall, 1'b0);
    chk("reset.issue_fire", issue_fire, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle: drive at negedge, check comb outputs, update model at posedge, check state at next negedge.
  task automatic step(input string tag, input bit v, input int s1, input bit s1e, input int s2, input bit s2e,
                      input int d, input bit de, input bit wv, input int wa, input bit fl);
    bit es, ef;
    int old[8];
    issue_valid = v; issue_src1 = 3'(s1); issue_src1_en = s1e; issue_src2 = 3'(s2); issue_src2_en = s2e;
    issue_dst = 3'(d); issue_dst_en = de; wb_valid = wv; wb_addr = 3'(wa); flush = fl;
    #1;
    es = m_stall(v, s1, s1e, s2, s2e, d, de, wv, wa);
    ef = v && !es;
    chk({tag, ".stall"}, stall, es);
    chk({tag, ".issue_fire"}, issue_fire, ef);
    @(posedge clk);
    old = m_cnt;
    if (wv && old[wa] == 0) m_err = 1;
`ifdef SCOREBOARD_PERF_EN
    if (es && m_stall_cycles < 16'hFFFF) m_stall_cycles++;
`endif
    if (fl) foreach (m_cnt[i]) m_cnt[i] = 0;
    else begin
      if (ef && de) m_cnt[d] = m_cnt[d] + 1;
      if (wv && old[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
    end
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    reset = 1'b0;
    do_reset();

    step("iss_r3", 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    chk("r3_mask", pending_mask, 8'b0000_1000);
    step("raw_r3", 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step("raw_r3_wt", 1, 3, 1, 0, 0, 0, 0, 1, 3, 0);
    chk("r3_released", pending_mask[3], 1'b0);

    step("r5_a", 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step("r5_b", 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step("r5_c", 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step("r5_sat", 1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step("r5_sat_wb", 1, 0, 0, 0, 0, 5, 1, 1, 5, 0);
    chk("r5_cnt_max", m_cnt[5], 3);

    step("r1_a", 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step("r1_incdec", 1, 0, 0, 0, 0, 1, 1, 1, 1, 0);
    chk("r1_still", pending_mask[1], 1'b1);

    step("uf_r6", 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
    chk("uf_set", err_underflow, 1'b1);
    step("uf_traffic", 1, 2, 1, 0, 0, 2, 1, 1, 5, 0);

    step("r4", 1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    step("flush_r7", 1, 0, 0, 0, 0, 7, 1, 0, 0, 1);
    chk("flush_mask", pending_mask, 8'h00);
    chk("flush_busy", busy, 1'b0);
    chk("flush_err_kept", err_underflow, 1'b1);

    for (int n = 0; n < 400; n++) begin
      int wa;
      wa = $urandom_range(0, 7);
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, wa, $urandom_range(0, 39) == 0);
      if (n == 200) begin
        do_reset();
      end
    end

    step("pre_reset", 1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
